// File: rtl/pe_out_merge.sv
// pe_out_merge: merges the two PE graph result streams into one tagged stream.
// Each input has a DEPTH-entry FIFO; a round-robin arbiter feeds a single
// output register. A sticky stall-timeout error is raised when the output
// is held valid without being taken for STALL_LIMIT consecutive cycles.
// Optional feature macro: PE_OUT_MERGE_CNT_EN adds per-input token counters
// cnt0/cnt1.
module pe_out_merge #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in0_valid,
    output logic                  in0_ready,
    input  logic [DATA_WIDTH-1:0] in0_data,
    input  logic                  in1_valid,
    output logic                  in1_ready,
    input  logic [DATA_WIDTH-1:0] in1_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_tag,
    output logic                  error_valid,
    output logic [15:0]           error_code
`ifdef PE_OUT_MERGE_CNT_EN
    ,
    output logic [31:0]           cnt0,
    output logic [31:0]           cnt1
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    logic [DATA_WIDTH-1:0] r_mem0 [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem1 [DEPTH];
    logic [PW-1:0]         r_wr0;
    logic [PW-1:0]         r_rd0;
    logic [PW-1:0]         r_wr1;
    logic [PW-1:0]         r_rd1;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_tag;
    logic                  r_rr;

    logic [SW-1:0]         r_stall_cnt;
    logic                  r_err_valid;
    logic [15:0]           r_err_code;

    logic                  w_empty0;
    logic                  w_empty1;
    logic                  w_full0;
    logic                  w_full1;
    logic                  w_push0;
    logic                  w_push1;
    logic                  w_load_en;
    logic                  w_gnt_any;
    logic                  w_gnt1;
    logic                  w_pop0;
    logic                  w_pop1;
    logic                  w_stall;
    logic [SW-1:0]         w_stall_nxt;

    // The extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign w_empty0 = (r_wr0 == r_rd0);
    assign w_empty1 = (r_wr1 == r_rd1);
    assign w_full0  = (r_wr0[AW] != r_rd0[AW]) && (r_wr0[AW-1:0] == r_rd0[AW-1:0]);
    assign w_full1  = (r_wr1[AW] != r_rd1[AW]) && (r_wr1[AW-1:0] == r_rd1[AW-1:0]);

    // Ready depends only on FIFO state (and reset), never on out_ready.
    assign in0_ready = !w_full0 && !rst;
    assign in1_ready = !w_full1 && !rst;
    assign w_push0   = in0_valid && in0_ready;
    assign w_push1   = in1_valid && in1_ready;

    // in1 wins when it is the only candidate, or when both wait and the pointer favours it.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_gnt_any = w_load_en && (!w_empty0 || !w_empty1);
    assign w_gnt1    = !w_empty1 && (w_empty0 || r_rr);
    assign w_pop0    = w_gnt_any && !w_gnt1;
    assign w_pop1    = w_gnt_any && w_gnt1;

    assign w_stall     = r_out_valid && !out_ready;
    assign w_stall_nxt = !w_stall ? '0 :
                         (r_stall_cnt == STALL_MAX) ? r_stall_cnt : r_stall_cnt + SW'(1);

    // FIFO storage writes; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push0) r_mem0[r_wr0[AW-1:0]] <= in0_data;
        if (w_push1) r_mem1[r_wr1[AW-1:0]] <= in1_data;
    end

    // FIFO pointer updates; reset empties both queues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr0 <= '0;
            r_rd0 <= '0;
            r_wr1 <= '0;
            r_rd1 <= '0;
        end else begin
            if (w_push0) r_wr0 <= r_wr0 + PW'(1);
            if (w_pop0)  r_rd0 <= r_rd0 + PW'(1);
            if (w_push1) r_wr1 <= r_wr1 + PW'(1);
            if (w_pop1)  r_rd1 <= r_rd1 + PW'(1);
        end
    end

    // Output register: load the granted head entry, or empty out once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= 1'b0;
            r_rr        <= 1'b0;
        end else if (w_gnt_any) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt1 ? r_mem1[r_rd1[AW-1:0]] : r_mem0[r_rd0[AW-1:0]];
            r_out_tag   <= w_gnt1;
            r_rr        <= !w_gnt1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Stall watchdog: saturating run-length of unaccepted output, sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_err_valid <= 1'b0;
            r_err_code  <= 16'd0;
        end else begin
            r_stall_cnt <= w_stall_nxt;
            if (w_stall_nxt == STALL_MAX) begin
                r_err_valid <= 1'b1;
                r_err_code  <= 16'd1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_tag     = r_out_tag;
    assign error_valid = r_err_valid;
    assign error_code  = r_err_code;

`ifdef PE_OUT_MERGE_CNT_EN
    logic [31:0] r_cnt0;
    logic [31:0] r_cnt1;

    // Accepted-token counters per input, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0) r_cnt0 <= r_cnt0 + 32'd1;
            if (w_push1) r_cnt1 <= r_cnt1 + 32'd1;
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    // Token counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pe_out_merge.sv
// Directed bench for pe_out_merge with a per-source scoreboard.
module tb_pe_out_merge;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in0_valid;
    logic          in0_ready;
    logic [DW-1:0] in0_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [DW-1:0] in1_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_tag;
    logic          error_valid;
    logic [15:0]   error_code;
`ifdef PE_OUT_MERGE_CNT_EN
    logic [31:0]   cnt0;
    logic [31:0]   cnt1;
`endif

    pe_out_merge #(.DATA_WIDTH(DW), .DEPTH(4), .STALL_LIMIT(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .in0_data    (in0_data),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in1_data    (in1_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .error_valid (error_valid),
        .error_code  (error_code)
`ifdef PE_OUT_MERGE_CNT_EN
        ,
        .cnt0        (cnt0),
        .cnt1        (cnt1)
`endif
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          tags[$];
    int            acc0 = 0;
    int            acc1 = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [DW-1:0] v);
        logic ok;
        ok = 1'b0;
        in0_valid = 1'b1;
        in0_data  = v;
        for (int t = 0; t < 20; t++) begin
            ok = in0_ready;
            tick();
            if (ok) break;
        end
        in0_valid = 1'b0;
        chk("push0_accepted", ok, 1);
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int t = 0; t < 40; t++) begin
            if (!out_valid) break;
            tick();
        end
        chk(name, out_valid, 0);
    endtask

    // Scoreboard: sample handshakes mid-cycle, where inputs and outputs are stable.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
            acc0 = 0;
            acc1 = 0;
        end else begin
            if (in0_valid && in0_ready) begin q0.push_back(in0_data); acc0++; end
            if (in1_valid && in1_ready) begin q1.push_back(in1_data); acc1++; end
            if (out_valid && out_ready) begin
                tags.push_back(out_tag);
                if (out_tag == 1'b0) begin
                    chk("sb_src0_pending", q0.size() > 0, 1);
                    if (q0.size() > 0) begin e = q0.pop_front(); chk("sb_data0", out_data, e); end
                end else begin
                    chk("sb_src1_pending", q1.size() > 0, 1);
                    if (q1.size() > 0) begin e = q1.pop_front(); chk("sb_data1", out_data, e); end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  i0;
        int  i1;
        logic ok;
        logic ok0;
        logic ok1;

        rst = 1'b1; out_ready = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
        repeat (2) tick();
        chk("rst_in0_ready", in0_ready, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_err_valid", error_valid, 0);
        chk("rst_err_code", error_code, 0);
        rst = 1'b0;
        tick();
        chk("idle_in0_ready", in0_ready, 1);

        // Same-cycle push on both inputs: in0 first, then in1.
        in0_valid = 1'b1; in0_data = 12; in1_valid = 1'b1; in1_data = 11; out_ready = 1'b1;
        tick();
        in0_valid = 1'b0; in1_valid = 1'b0;
        chk("t1_latency", out_valid, 0);
        tick();
        chk("t1_v0", out_valid, 1);
        chk("t1_d0", out_data, 12);
        chk("t1_tag0", out_tag, 0);
        tick();
        chk("t1_d1", out_data, 11);
        chk("t1_tag1", out_tag, 1);
        tick();
        chk("t1_empty", out_valid, 0);
        chk("t1_err", error_valid, 0);

        // Backpressure fills FIFO0 (one token sits in the output register).
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) push0(DW'(v));
        chk("t2_full", in0_ready, 0);
        chk("t2_hold_v", out_valid, 1);
        chk("t2_hold_d", out_data, 1);
        repeat (3) tick();
        chk("t2_full_hold", in0_ready, 0);
        chk("t2_stable_d", out_data, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_v", out_valid, 1);
            chk("t2_d", out_data, i + 1);
            chk("t2_tag", out_tag, 0);
            tick();
            if (i == 0) chk("t2_ready_back", in0_ready, 1);
        end
        chk("t2_done", out_valid, 0);

        // in1 streams while the output is blocked; in0 must stay ready.
        out_ready = 1'b0;
        in1_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in1_data = DW'(9 + acc);
            chk("t3_in0_ready", in0_ready, 1);
            ok = in1_ready;
            tick();
            if (ok) acc++;
        end
        in1_valid = 1'b0;
        chk("t3_accepted", acc, 5);
        chk("t3_in1_full", in1_ready, 0);
        drain("t3_drained");

        // Both inputs saturated: grants alternate starting from in0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tags.delete();
        out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
        i0 = 0; i1 = 0;
        for (int c = 0; c < 12; c++) begin
            in0_data = DW'(100 + i0);
            in1_data = DW'(200 + i1);
            ok0 = in0_ready;
            ok1 = in1_ready;
            tick();
            if (ok0) i0++;
            if (ok1) i1++;
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        drain("t4_drained");
        chk("t4_count", tags.size() >= 8, 1);
        for (int k = 0; k < 8; k++)
            if (k < tags.size()) chk("t4_tag", tags[k], k % 2);

        // Stall timeout after exactly 64 blocked cycles; sticky until reset.
        out_ready = 1'b0;
        push0(77);
        for (int t = 0; t < 5; t++) begin
            if (out_valid) break;
            tick();
        end
        chk("t5_out_valid", out_valid, 1);
        repeat (63) tick();
        chk("t5_err_pre", error_valid, 0);
        tick();
        chk("t5_err_valid", error_valid, 1);
        chk("t5_err_code", error_code, 1);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t5_err_sticky", error_valid, 1);
        chk("t5_code_sticky", error_code, 1);
        chk("t5_drained", out_valid, 0);
        rst = 1'b1;
        tick();
        chk("t5_err_clr", error_valid, 0);
        chk("t5_code_clr", error_code, 0);
        rst = 1'b0;
        tick();

        // Reset with tokens buffered discards them.
        out_ready = 1'b0;
        push0(31); push0(32); push0(33);
`ifdef PE_OUT_MERGE_CNT_EN
        chk("t6_cnt0_pre", cnt0, acc0);
        chk("t6_cnt1_pre", cnt1, acc1);
`endif
        rst = 1'b1;
        tick();
        chk("t6_out_valid", out_valid, 0);
        chk("t6_rst_ready", in0_ready, 0);
`ifdef PE_OUT_MERGE_CNT_EN
        chk("t6_cnt0", cnt0, 0);
        chk("t6_cnt1", cnt1, 0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk("t6_no_stale", out_valid, 0);
            tick();
        end

        chk("sb_q0_empty", q0.size(), 0);
        chk("sb_q1_empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
